// File: rtl/down_counter_timer.sv
// Loadable down-counter / interval timer with start/stop control, optional
// auto-reload and a one-cycle registered terminal-count pulse.
module down_counter_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             tc
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] reload_reg;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  // State updates on the falling edge; reset/load/stop/start follow a fixed
  // priority so simultaneous controls resolve deterministically.
  always_ff @(negedge clk) begin
    if (reset) begin
      state      <= IDLE;
      q          <= '0;
      reload_reg <= '0;
      tc         <= 1'b0;
    end else if (load) begin
      reload_reg <= load_val;
      q          <= load_val;
      state      <= IDLE;
      tc         <= 1'b0;
    end else begin
      tc <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (q != ZERO) begin
              state <= RUN;
            end else begin
              q     <= reload_reg;
              state <= (reload_reg != ZERO) ? RUN : IDLE;
            end
          end
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
          end else if (q != ZERO) begin
            q  <= q - ONE;
            tc <= (q == ONE);
            if (q == ONE && !auto_reload) state <= DONE;
          end else begin
            // Reached only in periodic mode: the zero cycle reloads.
            q <= reload_reg;
          end
        end
        DONE: begin
          if (start) begin
            q     <= reload_reg;
            state <= (reload_reg != ZERO) ? RUN : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_down_counter_timer.sv
// Self-checking bench for down_counter_timer: table-driven vectors with a
// scoreboard queue, plus a hand-written periodic-tick sequence.
module tb_down_counter_timer;

  logic       clk = 1'b0;
  logic       reset, load, start, stop, auto_reload;
  logic [3:0] load_val;
  logic [3:0] q;
  logic       busy, tc;

  int checks   = 0;
  int failures = 0;

  down_counter_timer #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val),
    .start(start), .stop(stop), .auto_reload(auto_reload),
    .q(q), .busy(busy), .tc(tc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r, l;
    logic [3:0] lv;
    logic       s, p, a;
    logic [3:0] eq;
    logic       eb, et;
  } vec_t;

  typedef struct {
    logic [3:0] q;
    logic       b, t;
    int         idx;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic void add(logic r, logic l, logic [3:0] lv, logic s,
                              logic p, logic a, logic [3:0] eq, logic eb, logic et);
    vec_t v;
    v.r = r; v.l = l; v.lv = lv; v.s = s; v.p = p; v.a = a;
    v.eq = eq; v.eb = eb; v.et = et;
    vecs.push_back(v);
  endfunction

  // Drive on the rising edge, let the DUT update on the falling edge,
  // then pop the expected record and compare.
  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    @(posedge clk);
    reset = v.r; load = v.l; load_val = v.lv;
    start = v.s; stop = v.p; auto_reload = v.a;
    e.q = v.eq; e.b = v.eb; e.t = v.et; e.idx = idx;
    sb.push_back(e);
    @(negedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    if (q !== e.q || busy !== e.b || tc !== e.t) begin
      failures++;
      $display("FAIL vec%0d: got q=%0d busy=%b tc=%b, expected q=%0d busy=%b tc=%b",
               e.idx, q, busy, tc, e.q, e.b, e.t);
    end
  endtask

  task automatic idle_inputs();
    @(posedge clk);
    reset = 0; load = 0; load_val = 0; start = 0; stop = 0;
  endtask

  initial begin
    int tc_count;
    int prev_tc;
    reset = 1; load = 0; load_val = 0; start = 0; stop = 0; auto_reload = 0;

    //   r  l  lv  s  p  a   q  b  t
    // reset with load/start toggling
    add(1, 1, 9,  1, 0, 0,  0, 0, 0);
    add(1, 0, 0,  1, 0, 0,  0, 0, 0);
    // one-shot of 3
    add(0, 1, 3,  0, 0, 0,  3, 0, 0);
    add(0, 0, 0,  1, 0, 0,  3, 1, 0);
    add(0, 0, 0,  0, 0, 0,  2, 1, 0);
    add(0, 0, 0,  0, 0, 0,  1, 1, 0);
    add(0, 0, 0,  0, 0, 0,  0, 0, 1);
    add(0, 0, 0,  0, 0, 0,  0, 0, 0);
    // restart from DONE in periodic mode: 3,2,1,0,3,2,1,0
    add(0, 0, 0,  1, 0, 1,  3, 1, 0);
    add(0, 0, 0,  0, 0, 1,  2, 1, 0);
    add(0, 0, 0,  0, 0, 1,  1, 1, 0);
    add(0, 0, 0,  0, 0, 1,  0, 1, 1);
    add(0, 0, 0,  0, 0, 1,  3, 1, 0);
    add(0, 0, 0,  0, 0, 1,  2, 1, 0);
    add(0, 0, 0,  0, 0, 1,  1, 1, 0);
    add(0, 0, 0,  0, 0, 1,  0, 1, 1);
    add(0, 0, 0,  0, 0, 1,  3, 1, 0);
    add(0, 0, 0,  0, 1, 1,  3, 0, 0);
    // load 5, pause at 3 for three edges, resume, start+stop -> stop wins
    add(0, 1, 5,  0, 0, 0,  5, 0, 0);
    add(0, 0, 0,  1, 0, 0,  5, 1, 0);
    add(0, 0, 0,  0, 0, 0,  4, 1, 0);
    add(0, 0, 0,  0, 0, 0,  3, 1, 0);
    add(0, 0, 0,  0, 1, 0,  3, 0, 0);
    add(0, 0, 0,  0, 1, 0,  3, 0, 0);
    add(0, 0, 0,  0, 1, 0,  3, 0, 0);
    add(0, 0, 0,  1, 0, 0,  3, 1, 0);
    add(0, 0, 0,  0, 0, 0,  2, 1, 0);
    add(0, 0, 0,  0, 0, 0,  1, 1, 0);
    add(0, 0, 0,  1, 1, 0,  1, 0, 0);
    add(0, 0, 0,  1, 0, 0,  1, 1, 0);
    add(0, 0, 0,  0, 0, 0,  0, 0, 1);
    // load 0 then start: stays idle
    add(0, 1, 0,  0, 0, 0,  0, 0, 0);
    add(0, 0, 0,  1, 0, 0,  0, 0, 0);
    add(0, 0, 0,  0, 0, 0,  0, 0, 0);
    // load 15 while running at 7, with an ignored start on the same edge
    add(0, 1, 8,  0, 0, 0,  8, 0, 0);
    add(0, 0, 0,  1, 0, 0,  8, 1, 0);
    add(0, 0, 0,  0, 0, 0,  7, 1, 0);
    add(0, 1, 15, 1, 0, 0, 15, 0, 0);
    add(0, 0, 0,  0, 0, 0, 15, 0, 0);
    // auto_reload dropped at the q==1 edge ends the run
    add(0, 1, 2,  0, 0, 1,  2, 0, 0);
    add(0, 0, 0,  1, 0, 1,  2, 1, 0);
    add(0, 0, 0,  0, 0, 1,  1, 1, 0);
    add(0, 0, 0,  0, 0, 0,  0, 0, 1);
    add(0, 0, 0,  0, 0, 0,  0, 0, 0);
    // reset mid-run at q=2, then start with reload_reg=0
    add(0, 1, 3,  0, 0, 0,  3, 0, 0);
    add(0, 0, 0,  1, 0, 0,  3, 1, 0);
    add(0, 0, 0,  0, 0, 0,  2, 1, 0);
    add(1, 0, 0,  0, 0, 0,  0, 0, 0);
    add(0, 0, 0,  1, 0, 0,  0, 0, 0);
    add(0, 0, 0,  0, 0, 0,  0, 0, 0);

    foreach (vecs[i]) apply(vecs[i], i);

    // Periodic tick with reload 4: period 5, so 20 edges after the start
    // edge hold exactly four single-cycle tc pulses.
    @(posedge clk);
    reset = 0; load = 1; load_val = 4; start = 0; stop = 0; auto_reload = 1;
    @(posedge clk);
    load = 0; start = 1;
    idle_inputs();
    tc_count = 0;
    prev_tc  = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      if (tc === 1'b1) tc_count++;
      if (tc === 1'b1 && prev_tc == 1) begin
        checks++;
        failures++;
        $display("FAIL tc_width: tc high on consecutive cycles at step %0d", k);
      end
      prev_tc = (tc === 1'b1) ? 1 : 0;
    end
    checks++;
    if (tc_count != 4) begin
      failures++;
      $display("FAIL periodic_tc: got %0d pulses, expected 4", tc_count);
    end
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL periodic_busy: got busy=%b, expected 1", busy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
